iris_train_sequencer: RTL and testbench

//  Upstream training driver for the 16-entry Boolean lookup-table learner.

---
 rtl/iris_train_sequencer_pkg.sv | 15 +
 rtl/iris_train_sequencer_if.sv | 40 ++++
 rtl/iris_train_sequencer.sv | 106 ++++++++++
 tb/tb_iris_train_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iris_train_sequencer_pkg.sv
// Shared types for the IRIS lookup-table training slice.
// FSM states and the learner index width.
package iris_train_sequencer_pkg;

  localparam int X_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/iris_train_sequencer_if.sv
// Dataset-read and learner bus of the training sequencer.
// The master drives reads and samples; the slave is RAM + learner.
interface iris_train_sequencer_if
  import iris_train_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [X_W-1:0]    mem_x;
  logic              mem_y;
  logic              lrn_valid;
  logic [X_W-1:0]    lrn_x;
  logic              lrn_y;
  logic              lrn_pred;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_x,
    input  mem_y,
    output lrn_valid,
    output lrn_x,
    output lrn_y,
    input  lrn_pred
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_x,
    output mem_y,
    input  lrn_valid,
    input  lrn_x,
    input  lrn_y,
    output lrn_pred
  );

endinterface

// File: rtl/iris_train_sequencer.sv
// Epoch driver for the lookup-table learner: streams the dataset,
// counts prediction misses per epoch, stops on convergence or limit.
module iris_train_sequencer
  import iris_train_sequencer_pkg::*;
#(
  parameter int N_SAMPLES  = 150,
  parameter int ADDR_W     = 8,
  parameter int MAX_EPOCHS = 16,
  parameter int EPOCH_W    = 5,
  parameter int ERR_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  iris_train_sequencer_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic [ERR_W-1:0]   last_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0] LAST_EPOCH =
    EPOCH_W'(MAX_EPOCHS - 1);

  state_t           state;
  logic [ERR_W-1:0] err_cnt;
  logic             miss;

  assign bus.lrn_x = bus.mem_x;
  assign bus.lrn_y = bus.mem_y;

  assign miss = bus.lrn_valid &&
                (bus.lrn_pred != bus.lrn_y);

  assign busy = (state == RUN) ||
                (state == DRAIN) ||
                (state == CHECK);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.lrn_valid <= 1'b0;
      epoch_cnt     <= '0;
      err_cnt       <= '0;
      last_err      <= '0;
      converged     <= 1'b0;
    end else if (abort) begin
      // In-flight sample is still presented this cycle; stop after.
      state         <= IDLE;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.lrn_valid <= 1'b0;
      epoch_cnt     <= '0;
      err_cnt       <= '0;
    end else begin
      bus.lrn_valid <= bus.mem_rd_en;
      if (miss)
        err_cnt <= err_cnt + 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= '0;
            epoch_cnt     <= '0;
            err_cnt       <= '0;
            converged     <= 1'b0;
          end
        end
        RUN: begin
          if (bus.mem_addr == LAST_ADDR) begin
            state         <= DRAIN;
            bus.mem_rd_en <= 1'b0;
          end else begin
            bus.mem_addr <= bus.mem_addr + 1'b1;
          end
        end
        DRAIN: state <= CHECK;
        CHECK: begin
          last_err <= err_cnt;
          if (err_cnt == '0) begin
            converged <= 1'b1;
            state     <= DONE;
          end else if (epoch_cnt == LAST_EPOCH) begin
            state <= DONE;
          end else begin
            epoch_cnt     <= epoch_cnt + 1'b1;
            err_cnt       <= '0;
            bus.mem_addr  <= '0;
            bus.mem_rd_en <= 1'b1;
            state         <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iris_train_sequencer.sv
// Scoreboard bench: reference training model feeds expected samples
// and final status; a negedge monitor pops and compares them.
module tb_iris_train_sequencer;
  import iris_train_sequencer_pkg::*;

  localparam int N    = 4;
  localparam int MAXE = 3;
  localparam int AW   = 8;
  localparam int EW   = 5;
  localparam int RW   = 8;

  typedef struct {
    int conv;
    int ep;
    int err;
  } stat_t;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic converged;
  logic [EW-1:0] epoch_cnt;
  logic [RW-1:0] last_err;

  iris_train_sequencer_if #(.ADDR_W(AW)) bus ();

  iris_train_sequencer #(
    .N_SAMPLES (N),
    .ADDR_W    (AW),
    .MAX_EPOCHS(MAXE),
    .EPOCH_W   (EW),
    .ERR_W     (RW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .converged(converged),
    .epoch_cnt(epoch_cnt),
    .last_err (last_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [X_W-1:0] ds_x [N];
  logic           ds_y [N];
  logic [X_W-1:0] rx;
  logic           ry;
  logic [15:0]    tbl;
  logic           tbl_clr;
  logic           stub;

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      rx <= ds_x[bus.mem_addr[1:0]];
      ry <= ds_y[bus.mem_addr[1:0]];
    end
  end

  assign bus.mem_x = rx;
  assign bus.mem_y = ry;
  assign bus.lrn_pred = stub ? ~bus.lrn_y
                             : tbl[bus.lrn_x];

  always @(posedge clk) begin
    if (tbl_clr)
      tbl <= '0;
    else if (bus.lrn_valid && !stub)
      tbl[bus.lrn_x] <= bus.lrn_y;
  end

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_samp [$];
  stat_t      exp_stat [$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Monitor: every presented sample and every done rise.
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (!rst && bus.lrn_valid) begin
      checks++;
      if (exp_samp.size() == 0) begin
        errors++;
        $display("FAIL sample_extra actual %0d expected none",
                 {bus.lrn_x, bus.lrn_y});
      end else begin
        logic [4:0] e;
        e = exp_samp.pop_front();
        if ({bus.lrn_x, bus.lrn_y} != e) begin
          errors++;
          $display("FAIL sample actual %0d expected %0d",
                   {bus.lrn_x, bus.lrn_y}, e);
        end
      end
    end
    if (!rst && done && !done_q) begin
      checks++;
      if (exp_stat.size() == 0) begin
        errors++;
        $display("FAIL status_extra actual 1 expected 0");
      end else begin
        stat_t s;
        s = exp_stat.pop_front();
        if (int'(converged) != s.conv ||
            int'(epoch_cnt) != s.ep ||
            int'(last_err) != s.err) begin
          errors++;
          $display("FAIL status actual %0d/%0d/%0d expected %0d/%0d/%0d",
                   converged, epoch_cnt, last_err,
                   s.conv, s.ep, s.err);
        end
      end
    end
    done_q = done;
  end

  // Reference: plain epoch loop over the dataset and a 16-bit table.
  task automatic model_run(input bit st, output int cyc);
    bit [15:0] t;
    int fe;
    int fe_err;
    int conv;
    t = '0;
    fe = 0;
    fe_err = 0;
    conv = 0;
    for (int e = 0; e < MAXE; e++) begin
      int errs;
      errs = 0;
      for (int i = 0; i < N; i++) begin
        bit p;
        exp_samp.push_back({ds_x[i], ds_y[i]});
        p = st ? !ds_y[i] : t[ds_x[i]];
        if (p != ds_y[i]) errs++;
        if (!st) t[ds_x[i]] = ds_y[i];
      end
      fe = e;
      fe_err = errs;
      if (errs == 0) begin
        conv = 1;
        break;
      end
    end
    exp_stat.push_back('{conv, fe, fe_err});
    cyc = (fe + 1) * (N + 2);
  endtask

  task automatic clr_learner(input bit st);
    stub = st;
    tbl_clr = 1'b1;
    @(posedge clk);
    #1 tbl_clr = 1'b0;
  endtask

  task automatic do_run(input bit st, input int inj_a,
                        input int inj_b, input int mid_err);
    int exp_cyc;
    int c;
    clr_learner(st);
    model_run(st, exp_cyc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 1;
    while (!done && c <= 200) begin
      if (c <= N + 2) begin
        chk("rd_en", int'(bus.mem_rd_en), int'(c <= N));
        chk("lrn_valid", int'(bus.lrn_valid),
            int'(c >= 2 && c <= N + 1));
        if (c <= N)
          chk("mem_addr", int'(bus.mem_addr), c - 1);
        if (c == 1) begin
          chk("busy_run", int'(busy), 1);
          chk("epoch0", int'(epoch_cnt), 0);
        end
      end
      if (c == N + 3 && mid_err >= 0)
        chk("last_err_ep0", int'(last_err), mid_err);
      start = (c == inj_a) || (c == inj_b);
      @(posedge clk);
      #1 start = 1'b0;
      c++;
    end
    chk("run_cycles", c - 1, exp_cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual running expected finished");
    $fatal(1);
  end

  initial begin
    int lim;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    stub = 1'b0;
    tbl_clr = 1'b1;
    for (int i = 0; i < N; i++) begin
      ds_x[i] = 4'd3;
      ds_y[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_conv", int'(converged), 0);
    chk("rst_epoch", int'(epoch_cnt), 0);
    chk("rst_last_err", int'(last_err), 0);
    chk("rst_rd_en", int'(bus.mem_rd_en), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_lrn_valid", int'(bus.lrn_valid), 0);
    rst = 1'b0;
    tbl_clr = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 chk("idle_rd_en", int'(bus.mem_rd_en), 0);
    end

    // Constant dataset, real learner: one miss then converge.
    do_run(1'b0, 0, 0, 1);
    chk("t2_conv", int'(converged), 1);
    chk("t2_epoch", int'(epoch_cnt), 1);

    // Always-wrong learner: run out of epochs.
    do_run(1'b1, 0, 0, 4);
    chk("t3_conv", int'(converged), 0);
    chk("t3_last_err", int'(last_err), 4);

    // Abort in the 2nd RUN cycle of epoch 1.
    clr_learner(1'b1);
    for (int i = 0; i < N; i++)
      exp_samp.push_back({ds_x[i], ds_y[i]});
    exp_samp.push_back({ds_x[0], ds_y[0]});
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (N + 3) @(posedge clk);
    #1;
    chk("ab_epoch1", int'(epoch_cnt), 1);
    chk("ab_addr", int'(bus.mem_addr), 1);
    chk("ab_lrn_valid", int'(bus.lrn_valid), 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_rd_en", int'(bus.mem_rd_en), 0);
    chk("ab_lrn_valid_off", int'(bus.lrn_valid), 0);
    chk("ab_epoch_clr", int'(epoch_cnt), 0);
    chk("ab_last_err_kept", int'(last_err), 4);
    @(posedge clk);
    #1 chk("ab_lrn_valid_idle", int'(bus.lrn_valid), 0);
    do_run(1'b0, 0, 0, 1);

    // start pulses in RUN and CHECK must not disturb the run.
    do_run(1'b1, 2, N + 2, 4);
    chk("ign_epoch", int'(epoch_cnt), MAXE - 1);

    // abort beats start in DONE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("sa_done", int'(done), 0);
    chk("sa_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 chk("sa_rd_en", int'(bus.mem_rd_en), 0);

    // Randomized datasets; narrow x ranges force label conflicts.
    for (int r = 0; r < 8; r++) begin
      lim = (r < 4) ? 1 : 15;
      for (int i = 0; i < N; i++) begin
        ds_x[i] = X_W'($urandom_range(0, lim));
        ds_y[i] = 1'($urandom_range(0, 1));
      end
      do_run(1'($urandom_range(0, 3) == 0), 0, 0, -1);
    end

    repeat (2) @(posedge clk);
    chk("samp_left", exp_samp.size(), 0);
    chk("stat_left", exp_stat.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
